// File: rtl/graphite_rect_fill.sv
// Rectangle/clear fill engine: command words load corners/colour, then a raster walk emits one VRAM write per pixel.
// First write appears two edges after the command is accepted; each write holds until vram_ack_i, and commands stall while busy.
`timescale 1ns/1ps
module graphite_rect_fill #(
    parameter int FB_WIDTH         = 128,
    parameter int FB_HEIGHT        = 128,
    parameter int CMD_STREAM_WIDTH = 16,
    parameter int ADDR_WIDTH       = 16
) (
    input  logic                        clk,
    input  logic                        reset_i,
    input  logic                        cmd_axis_tvalid_i,
    output logic                        cmd_axis_tready_o,
    input  logic [CMD_STREAM_WIDTH-1:0] cmd_axis_tdata_i,
    input  logic                        vram_ack_i,
    output logic                        vram_sel_o,
    output logic                        vram_wr_o,
    output logic [3:0]                  vram_mask_o,
    output logic [ADDR_WIDTH-1:0]       vram_addr_o,
    output logic [15:0]                 vram_data_out_o,
    output logic                        busy_o,
    output logic                        done_o
);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;

    localparam logic [3:0] OP_SET_X0  = 4'd1;
    localparam logic [3:0] OP_SET_Y0  = 4'd2;
    localparam logic [3:0] OP_SET_X1  = 4'd3;
    localparam logic [3:0] OP_SET_Y1  = 4'd4;
    localparam logic [3:0] OP_COLOR   = 4'd5;
    localparam logic [3:0] OP_CLEAR   = 4'd6;
    localparam logic [3:0] OP_FILL    = 4'd7;

    localparam logic signed [12:0]  W_MAX    = 13'(FB_WIDTH - 1);
    localparam logic signed [12:0]  H_MAX    = 13'(FB_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_WIDTH);

    state_t                  state_q;
    logic [11:0]             x0_q, y0_q, x1_q, y1_q;
    logic [15:0]             color_q;
    logic                    clear_q;
    logic [11:0]             xmin_q, xmax_q, ymax_q, x_q, y_q;
    logic [ADDR_WIDTH-1:0]   addr_q, row_q;
    logic [15:0]             data_q;
    logic                    sel_q, wr_q, done_q;

    logic [3:0]              opcode;
    logic [11:0]             operand;
    logic signed [12:0]      xa, xb, ya, yb;
    logic signed [12:0]      xlo_d, xhi_d, ylo_d, yhi_d;
    logic                    empty_d;
    logic [ADDR_WIDTH-1:0]   base_d;

    assign opcode  = cmd_axis_tdata_i[15:12];
    assign operand = cmd_axis_tdata_i[11:0];

    // Bounds are sorted and clipped once per command; the multiply here is off the per-pixel path.
    always_comb begin
        xa = {x0_q[11], x0_q};
        xb = {x1_q[11], x1_q};
        ya = {y0_q[11], y0_q};
        yb = {y1_q[11], y1_q};
        if (clear_q) begin
            xlo_d = '0;
            xhi_d = W_MAX;
            ylo_d = '0;
            yhi_d = H_MAX;
        end else begin
            xlo_d = (xa < xb) ? xa : xb;
            xhi_d = (xa < xb) ? xb : xa;
            ylo_d = (ya < yb) ? ya : yb;
            yhi_d = (ya < yb) ? yb : ya;
            if (xlo_d < 13'sd0) xlo_d = '0;
            if (ylo_d < 13'sd0) ylo_d = '0;
            if (xhi_d > W_MAX)  xhi_d = W_MAX;
            if (yhi_d > H_MAX)  yhi_d = H_MAX;
        end
        empty_d = (xlo_d > xhi_d) || (ylo_d > yhi_d);
        base_d  = ADDR_WIDTH'(32'(ylo_d[11:0]) * 32'(FB_WIDTH) + 32'(xlo_d[11:0]));
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= 16'hF000;
            clear_q <= 1'b0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            data_q  <= '0;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_axis_tvalid_i) begin
                        case (opcode)
                            OP_SET_X0: x0_q    <= operand;
                            OP_SET_Y0: y0_q    <= operand;
                            OP_SET_X1: x1_q    <= operand;
                            OP_SET_Y1: y1_q    <= operand;
                            OP_COLOR:  color_q <= {4'hF, operand};
                            OP_CLEAR, OP_FILL: begin
                                clear_q <= (opcode == OP_CLEAR);
                                state_q <= SETUP;
                            end
                            default: ;
                        endcase
                    end
                end
                SETUP: begin
                    if (empty_d) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        xmin_q  <= xlo_d[11:0];
                        xmax_q  <= xhi_d[11:0];
                        ymax_q  <= yhi_d[11:0];
                        x_q     <= xlo_d[11:0];
                        y_q     <= ylo_d[11:0];
                        addr_q  <= base_d;
                        row_q   <= base_d;
                        data_q  <= color_q;
                        sel_q   <= 1'b1;
                        wr_q    <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    // row_q tracks the address of (xmin, y) so a row wrap is a single add.
                    if (vram_ack_i) begin
                        if (x_q < xmax_q) begin
                            x_q    <= x_q + 12'd1;
                            addr_q <= addr_q + 1'b1;
                        end else if (y_q < ymax_q) begin
                            x_q    <= xmin_q;
                            y_q    <= y_q + 12'd1;
                            row_q  <= row_q + ROW_STEP;
                            addr_q <= row_q + ROW_STEP;
                        end else begin
                            sel_q   <= 1'b0;
                            wr_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_axis_tready_o = (state_q == IDLE);
    assign busy_o            = (state_q != IDLE);
    assign done_o            = done_q;
    assign vram_sel_o        = sel_q;
    assign vram_wr_o         = wr_q;
    assign vram_mask_o       = 4'hF;
    assign vram_addr_o       = addr_q;
    assign vram_data_out_o   = data_q;

endmodule

// File: tb/tb_graphite_rect_fill.sv
// Directed bench for graphite_rect_fill: rectangles, clipping, stalls, full clear and reset abort.
`timescale 1ns/1ps
module tb_graphite_rect_fill;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        tvalid;
    logic        tready;
    logic [15:0] tdata;
    logic        ack;
    logic        sel, wr;
    logic [3:0]  mask;
    logic [15:0] addr;
    logic [15:0] data;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          done_cnt   = 0;
    int          tready_bad = 0;
    int          exp6[6]    = '{386, 387, 388, 514, 515, 516};

    graphite_rect_fill #(
        .FB_WIDTH(128), .FB_HEIGHT(128), .CMD_STREAM_WIDTH(16), .ADDR_WIDTH(16)
    ) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .cmd_axis_tvalid_i (tvalid),
        .cmd_axis_tready_o (tready),
        .cmd_axis_tdata_i  (tdata),
        .vram_ack_i        (ack),
        .vram_sel_o        (sel),
        .vram_wr_o         (wr),
        .vram_mask_o       (mask),
        .vram_addr_o       (addr),
        .vram_data_out_o   (data),
        .busy_o            (busy),
        .done_o            (done)
    );

    always #5 clk = ~clk;

    // Inputs change 2ns after a rising edge, so values seen at the falling edge are what the next edge samples.
    always @(negedge clk) begin
        if (sel && ack) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(data);
        end
        if (done) done_cnt++;
        if (busy && tready) tready_bad++;
    end

    task automatic clr_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt   = 0;
        tready_bad = 0;
    endtask

    task automatic send(input logic [3:0] op, input logic [11:0] d);
        int n = 0;
        @(posedge clk); #2;
        tvalid = 1'b1;
        tdata  = {op, d};
        @(negedge clk);
        while (!tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tready) begin
            checks++; errors++;
            $display("FAIL send_timeout op=%0d tready=%b required 1", op, tready);
        end
        @(posedge clk); #2;
        tvalid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout busy=%b required 0", busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic set_rect(input logic [11:0] x0, input logic [11:0] y0,
                            input logic [11:0] x1, input logic [11:0] y1);
        send(4'd1, x0);
        send(4'd2, y0);
        send(4'd3, x1);
        send(4'd4, y1);
    endtask

    task automatic test_reset();
        reset_i = 1'b1; tvalid = 1'b0; tdata = '0; ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (sel !== 1'b0)     begin errors++; $display("FAIL reset_sel got %b want 0", sel); end
        checks++; if (wr !== 1'b0)      begin errors++; $display("FAIL reset_wr got %b want 0", wr); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (mask !== 4'hF)    begin errors++; $display("FAIL reset_mask got %h want f", mask); end
        checks++; if (addr !== 16'd0)   begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
        checks++; if (data !== 16'h0)   begin errors++; $display("FAIL reset_data got %h want 0", data); end
        checks++; if (tready !== 1'b1)  begin errors++; $display("FAIL reset_tready got %b want 1", tready); end
        @(posedge clk); #2;
        reset_i = 1'b0;
    endtask

    task automatic test_fill_basic();
        int bad = 0;
        ack = 1'b1;
        send(4'd5, 12'h5A3);
        set_rect(12'd2, 12'd3, 12'd4, 12'd4);
        clr_mon();
        send(4'd7, 12'd0);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_setup_busy got %b want 1", busy); end
        checks++; if (sel !== 1'b0)  begin errors++; $display("FAIL basic_setup_sel got %b want 0", sel); end
        @(negedge clk);
        checks++; if (sel !== 1'b1 || wr !== 1'b1) begin errors++; $display("FAIL basic_first_selwr got %b%b want 11", sel, wr); end
        checks++; if (addr !== 16'd386) begin errors++; $display("FAIL basic_first_addr got %0d want 386", addr); end
        checks++; if (data !== 16'hF5A3) begin errors++; $display("FAIL basic_first_data got %h want f5a3", data); end
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL basic_tready_busy got %b want 0", tready); end
        wait_idle(100);
        checks++; if (wr_addr_q.size() != 6) begin errors++; $display("FAIL basic_count got %0d want 6", wr_addr_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wr_addr_q[i] !== 16'(exp6[i])) begin errors++; $display("FAIL basic_addr%0d got %0d want %0d", i, wr_addr_q[i], exp6[i]); end
        end
        foreach (wr_data_q[i]) if (wr_data_q[i] !== 16'hF5A3) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_data got %0d bad words want 0", bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done got %0d pulses want 1", done_cnt); end
        checks++; if (sel !== 1'b0 || tready !== 1'b1) begin errors++; $display("FAIL basic_end sel=%b tready=%b want 0,1", sel, tready); end
    endtask

    task automatic test_swapped();
        set_rect(12'd4, 12'd4, 12'd2, 12'd3);
        clr_mon();
        send(4'd7, 12'd0);
        wait_idle(100);
        checks++; if (wr_addr_q.size() != 6) begin errors++; $display("FAIL swap_count got %0d want 6", wr_addr_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wr_addr_q[i] !== 16'(exp6[i])) begin errors++; $display("FAIL swap_addr%0d got %0d want %0d", i, wr_addr_q[i], exp6[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL swap_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_clip_negative();
        set_rect(12'hFFB, 12'hFFB, 12'd1, 12'd0);
        clr_mon();
        send(4'd7, 12'd0);
        wait_idle(100);
        checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL clipneg_count got %0d want 2", wr_addr_q.size()); end
        checks++; if (wr_addr_q[0] !== 16'd0) begin errors++; $display("FAIL clipneg_addr0 got %0d want 0", wr_addr_q[0]); end
        checks++; if (wr_addr_q[1] !== 16'd1) begin errors++; $display("FAIL clipneg_addr1 got %0d want 1", wr_addr_q[1]); end
    endtask

    task automatic test_empty();
        set_rect(12'd200, 12'd0, 12'd300, 12'd5);
        clr_mon();
        send(4'd7, 12'd0);
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL empty_cyc1 done=%b busy=%b want 0,1", done, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL empty_cyc2 done=%b busy=%b want 1,0", done, busy); end
        repeat (4) @(negedge clk);
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL empty_writes got %0d want 0", wr_addr_q.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL empty_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall();
        int          stall_chk = 0;
        int          stall_bad = 0;
        logic        prev_stall = 1'b0;
        logic [15:0] p_addr = '0;
        logic [15:0] p_data = '0;
        int          bad = 0;
        send(4'd5, 12'h123);
        set_rect(12'd2, 12'd3, 12'd4, 12'd4);
        ack = 1'b0;
        clr_mon();
        send(4'd7, 12'd0);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
            if (sel && prev_stall) begin
                stall_chk++;
                if (addr !== p_addr || data !== p_data) stall_bad++;
            end
            prev_stall = sel && !ack;
            p_addr = addr;
            p_data = data;
            @(posedge clk); #2;
            ack = (k % 4 == 3);
        end
        ack = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (stall_bad != 0 || stall_chk == 0) begin errors++; $display("FAIL stall_stable got %0d unstable of %0d want 0", stall_bad, stall_chk); end
        checks++; if (wr_addr_q.size() != 6) begin errors++; $display("FAIL stall_count got %0d want 6", wr_addr_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wr_addr_q[i] !== 16'(exp6[i])) begin errors++; $display("FAIL stall_addr%0d got %0d want %0d", i, wr_addr_q[i], exp6[i]); end
        end
        foreach (wr_data_q[i]) if (wr_data_q[i] !== 16'hF123) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_data got %0d bad words want 0", bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_clear();
        int bad_a = 0;
        int bad_d = 0;
        ack = 1'b1;
        send(4'd5, 12'h0AB);
        clr_mon();
        send(4'd6, 12'd0);
        wait_idle(20000);
        checks++; if (wr_addr_q.size() != 16384) begin errors++; $display("FAIL clear_count got %0d want 16384", wr_addr_q.size()); end
        foreach (wr_addr_q[i]) begin
            if (wr_addr_q[i] !== 16'(i)) bad_a++;
            if (wr_data_q[i] !== 16'hF0AB) bad_d++;
        end
        checks++; if (bad_a != 0) begin errors++; $display("FAIL clear_addrs got %0d out of order want 0", bad_a); end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL clear_data got %0d bad words want 0", bad_d); end
        checks++; if (tready_bad != 0) begin errors++; $display("FAIL clear_tready got %0d ready cycles while busy want 0", tready_bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL clear_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_abort();
        int n = 0;
        ack = 1'b1;
        send(4'd6, 12'd0);
        repeat (50) @(negedge clk);
        @(posedge clk); #2;
        reset_i = 1'b1;
        @(posedge clk); #2;
        reset_i = 1'b0;
        clr_mon();
        @(negedge clk);
        checks++; if (sel !== 1'b0 || wr !== 1'b0) begin errors++; $display("FAIL abort_selwr got %b%b want 00", sel, wr); end
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL abort_tready got %b want 1", tready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        repeat (20) @(negedge clk);
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL abort_writes got %0d want 0", wr_addr_q.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt); end
        send(4'd6, 12'd0);
        @(negedge clk);
        while (!sel && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (data !== 16'hF000) begin errors++; $display("FAIL abort_color got %h want f000", data); end
        checks++; if (addr !== 16'd0) begin errors++; $display("FAIL abort_addr got %0d want 0", addr); end
        @(posedge clk); #2;
        reset_i = 1'b1;
        @(posedge clk); #2;
        reset_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill_basic();
        test_swapped();
        test_clip_negative();
        test_empty();
        test_stall();
        test_clear();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
